// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display scan path.
package seg_pkg;

    typedef logic [3:0] digit_t;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/scan_slot_counter.sv
// Slot timing for the display scan: a cycle counter inside each digit slot,
// the slot index, a terminal-count flag and a registered end-of-frame pulse.
module scan_slot_counter #(
    parameter int DIGIT_CYCLES = 100_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear_i,
    input  logic                            run_i,
    output logic [$clog2(DIGIT_CYCLES)-1:0] cnt_o,
    output logic [1:0]                      idx_o,
    output logic [1:0]                      idx_next_o,
    output logic                            tc_o,
    output logic                            frame_tick_o
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             frame_tick_q;
    logic             tc;

    assign tc = (cnt_q == LAST);

    // Advance the in-slot counter, wrapping into the next slot at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (clear_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (run_i) begin
            if (tc) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Register the counter and pre-decode the last cycle of slot 3 so the pulse lands on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_tick_q <= (cnt_d == LAST) && (idx_d == 2'd3);
        end
    end

    assign cnt_o        = cnt_q;
    assign idx_o        = idx_q;
    assign idx_next_o   = idx_d;
    assign tc_o         = tc;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: sequences blank/show time per
// digit, drives the active-low anodes, and double-buffers the digit values so
// the visible digits only change at frame boundaries (or at once while dark).
module display_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    input  logic       load,
    input  logic [3:0] digit_in [3:0],
    output logic [3:0] digit_array [3:0],
    output logic [1:0] anode_index,
    output logic [3:0] an,
    output logic       frame_tick,
    output logic       pending
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic             tc;
    logic             frame_tick_w;
    logic             run;
    logic             clear;

    logic [3:0]       an_q, an_d;
    digit_t           shadow_q [NUM_DIGITS-1:0];
    digit_t           shadow_d [NUM_DIGITS-1:0];
    digit_t           array_q  [NUM_DIGITS-1:0];
    digit_t           array_d  [NUM_DIGITS-1:0];
    logic             pending_q, pending_d;
    logic             commit;

    assign run   = (state_q != IDLE);
    assign clear = ~en;

    scan_slot_counter #(
        .DIGIT_CYCLES(DIGIT_CYCLES)
    ) u_slot_counter (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .run_i       (run),
        .cnt_o       (cnt),
        .idx_o       (idx),
        .idx_next_o  (idx_next),
        .tc_o        (tc),
        .frame_tick_o(frame_tick_w)
    );

    // Next scan phase: dropping enable abandons the slot, otherwise blank then show each slot.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = BLANK;
                BLANK:   if (cnt == BLANK_LAST) state_d = SHOW;
                SHOW:    if (tc) state_d = BLANK;
                default: state_d = IDLE;
            endcase
        end
    end

    // Decode the anode drive from the upcoming phase and slot so the register holds it in step.
    always_comb begin
        an_d = 4'b1111;
        if ((state_d == SHOW) && digit_mask[idx_next]) begin
            an_d[idx_next] = 1'b0;
        end
    end

    // Commit the shadow at a frame boundary or immediately while dark; a new load always wins the shadow.
    always_comb begin
        commit    = pending_q && (frame_tick_w || (state_q == IDLE));
        shadow_d  = shadow_q;
        array_d   = array_q;
        pending_d = pending_q;
        if (commit) begin
            array_d   = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = digit_in;
            pending_d = 1'b1;
        end
    end

    // State, anode and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            an_q      <= 4'b1111;
            shadow_q  <= '{default: '0};
            array_q   <= '{default: '0};
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            an_q      <= an_d;
            shadow_q  <= shadow_d;
            array_q   <= array_d;
            pending_q <= pending_d;
        end
    end

    assign an          = an_q;
    assign anode_index = idx;
    assign frame_tick  = frame_tick_w;
    assign pending     = pending_q;
    assign digit_array = array_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the 4-digit seven-segment display. It generates the digit select index and active-low anode drive, inserts anti-ghosting blank time between digits, and double-buffers the four digit values so they change only at frame boundaries. Its `anode_index` and `digit_array` outputs feed `digit_handler`; its `an` output drives the board anodes directly.

## Interface

**Parameters**

- `DIGIT_CYCLES`, default 100_000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 1_000: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ `BLANK_CYCLES` < `DIGIT_CYCLES`.

**Ports**

- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: scan enable. When low, the display is dark.
- `digit_mask`  in  4: per-digit enable. Bit i = 0 keeps anode i off during its slot.
- `load`  in  1: one-cycle strobe that captures `digit_in`.
- `digit_in`  in  4×4: unpacked `[3:0]` array of 4-bit digit values to display.
- `digit_array`  out  4×4: committed digit values, to `digit_handler`.
- `anode_index`  out  2: current slot index, to `digit_handler`.
- `an`  out  4: anode drive, active-low, at most one bit low.
- `frame_tick`  out  1: one-cycle pulse on the last cycle of slot 3.
- `pending`  out  1: a loaded value is waiting to be committed.

## Operation

**States:** `IDLE`, `BLANK`, `SHOW`.

- **`IDLE`**
  - `an` = 4'b1111, `anode_index` = 0, slot counter = 0.
  - `en` = 1 → `BLANK`, slot 0.
- **`BLANK`**
  - `an` = 4'b1111.
  - Counter runs 0 .. `BLANK_CYCLES`-1, then → `SHOW`.
- **`SHOW`**
  - `an[anode_index]` = ~`digit_mask[anode_index]`; all other anode bits = 1.
  - Counter runs `BLANK_CYCLES` .. `DIGIT_CYCLES`-1.
  - At the end of the slot: counter → 0, `anode_index` += 1 (wraps 3→0), → `BLANK`.
- **`en` = 0:** from any state, go to `IDLE` on the next edge. A partial slot is abandoned, not completed.
- **Masked digits:** a masked digit still consumes its full slot, so per-digit duty cycle stays 1/4 × (`DIGIT_CYCLES`−`BLANK_CYCLES`)/`DIGIT_CYCLES`.

**Buffering**

- `load` = 1 → `digit_in` captured into a shadow register; `pending` ← 1. The latest load overwrites earlier ones.
- **Commit:** on the `frame_tick` cycle with `pending` = 1, `digit_array` ← shadow and `pending` ← 0.
- **`load` on the commit cycle:** the commit uses the pre-load shadow. The new value enters the shadow and `pending` stays 1, so it commits at the next frame boundary.
- **In `IDLE`:** a `load` commits the cycle after capture (display is dark, so no tearing). `pending` pulses high for that one cycle.

## Timing

- **Reset values:** `an` = 4'b1111, `anode_index` = 0, `digit_array` = all 0, shadow = all 0, `pending` = 0, `frame_tick` = 0, state `IDLE`, counter 0.
- **Outputs:** all registered; no combinational path from any input to any output.
- **Start-up:** `en` rises in cycle t → `BLANK` from t+1; first anode goes low at t+1+`BLANK_CYCLES`.
- **Frame period:** 4×`DIGIT_CYCLES`. `frame_tick` is high in the final cycle of slot 3 only.
- **Index change:** `anode_index` changes only at a slot boundary, which is always in `BLANK`. No anode is ever low in the same cycle the index changes.
- **Commit timing:** `digit_array` updates in the cycle after `frame_tick`, coincident with slot 0 `BLANK`.
- **Reset mid-slot:** returns to reset values on the next edge. A pending load is discarded.
- **Counter width:** `$clog2(DIGIT_CYCLES)`, compared with `==` at terminal count; no overflow is possible.

## Structure

- **Package `seg_pkg`:**
  - `typedef logic [3:0] digit_t`
  - `localparam NUM_DIGITS = 4`
  - state enum `scan_state_t` {`IDLE`, `BLANK`, `SHOW`}
- **Sub-module `scan_slot_counter`:** counter plus slot index with terminal-count and `frame_tick` outputs. The top level holds the FSM, the shadow/commit registers and the anode decode.

## Test plan

Run with `DIGIT_CYCLES` = 8, `BLANK_CYCLES` = 2.

1. **Basic scan:** reset, then `en` = 1, `digit_mask` = 4'hF → `an` runs 1111 ×2, 1110 ×6, 1111 ×2, 1101 ×6, … 0111 ×6. `frame_tick` pulses every 32 cycles; `anode_index` sequence is 0,1,2,3,0.
2. **Masking:** `digit_mask` = 4'b1010 → `an` stays 1111 throughout slots 0 and 2. Slot lengths remain 8 cycles.
3. **Tear-free load:** `load` of {4'h1,4'h2,4'h3,4'h4} mid-slot 1 → `digit_array` unchanged and `pending` = 1 until the cycle after `frame_tick`, then `digit_array` = new value and `pending` = 0. A second `load` exactly on the `frame_tick` cycle commits one frame later.
4. **Disable mid-slot / `IDLE` load:** drop `en` during `SHOW` of slot 2 → next cycle `an` = 1111 and `anode_index` = 0. A `load` while idle appears on `digit_array` two cycles later.
5. **Synchronous reset:** assert `rst` during `SHOW` with `pending` = 1 → next edge gives all reset values, `pending` = 0, `digit_array` = 0.
6. **Anode invariant:** random `en`/`load`/`digit_mask` for 10k cycles → `an` never has more than one bit low, and `an` = 1111 in every cycle where `anode_index` changed.
